// File: rtl/rt_disp_pkg.sv
// Shared definitions for the display scanner: active-low segment codes
// (gfedcba) and the BCD nibble type.
package rt_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/rt_display_scanner_bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles show a dash; blank_i overrides everything.
module bcd_to_7seg
  import rt_disp_pkg::*;
(
  input  bcd_t       bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_DASH;
    if (blank_i) begin
      seg_n_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/rt_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner fed by a packed BCD bus.
// Takes a tear-free snapshot per frame and scans one digit per refresh slot.
module rt_display_scanner
  import rt_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD_CYCLES  = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD_W  = TW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]           digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    arm_q, arm_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_start_q, frame_start_d;

  bcd_t                    snap_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lead_zero;
  bcd_t                    sel_nib;
  logic                    blank_sel;
  logic [6:0]              dec_seg_n;
  logic                    tick;

  // lead_zero[i]: nibble i and every nibble above it are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign snap_nib[gi]  = snap_digits_q[4*gi +: 4];
    assign lead_zero[gi] = ~|snap_digits_q[4*NUM_DIGITS-1:4*gi];
  end

  assign sel_nib   = snap_nib[digit_idx_q];
  assign blank_sel = (BLANK_LEADING != 0) && (digit_idx_q != '0) && lead_zero[digit_idx_q];
  assign tick      = (tick_cnt_q == TICK_MAX);

  bcd_to_7seg u_dec (
    .bcd_i   (sel_nib),
    .blank_i (blank_sel),
    .seg_n_o (dec_seg_n)
  );

  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    digit_idx_d   = digit_idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    arm_d         = arm_q;
    frame_start_d = 1'b0;
    seg_n_d       = SEG_BLANK;
    dp_n_d        = 1'b1;
    an_n_d        = '1;

    if (!en) begin
      // Frozen and dark; the next enabled cycle restarts the frame.
      arm_d = 1'b1;
    end else if (arm_q) begin
      arm_d         = 1'b0;
      tick_cnt_d    = '0;
      digit_idx_d   = '0;
      snap_digits_d = digits_bcd;
      snap_dp_d     = dp_mask;
      frame_start_d = 1'b1;
    end else begin
      seg_n_d = dec_seg_n;
      if (tick_cnt_q >= GUARD_W) begin
        an_n_d[digit_idx_q] = 1'b0;
        dp_n_d              = ~snap_dp_q[digit_idx_q];
      end

      if (tick) begin
        tick_cnt_d = '0;
        if (digit_idx_q == IDX_MAX) begin
          digit_idx_d   = '0;
          snap_digits_d = digits_bcd;
          snap_dp_d     = dp_mask;
          frame_start_d = 1'b1;
        end else begin
          digit_idx_d = digit_idx_q + 1'b1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q    <= '0;
      digit_idx_q   <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      arm_q         <= 1'b1;
      seg_n_q       <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      digit_idx_q   <= digit_idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      arm_q         <= arm_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/rt_display_scanner.md
Name: rt_display_scanner

Overview:
Reader side of the real-time mod-N counter chain. It takes the packed BCD digit bus that the counter chain writes and drives a time-multiplexed common-anode 7-segment display. It samples a tear-free snapshot once per frame, then scans one digit per refresh tick. Guard cycles suppress ghosting, and optional leading-zero blanking is supported. It sits between the counter chain and the board display pins.

Parameters:
NUM_DIGITS, 4, number of display digits; index 0 is the least significant; must be >= 2.
REFRESH_DIV, 50000, clk cycles each digit is held; must be >= 2.
GUARD_CYCLES, 2, cycles at the start of each digit slot with all anodes off; must be < REFRESH_DIV.
BLANK_LEADING, 1, when 1, leading zero digits are blanked.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; when low, the display is dark and the scan is frozen.
digits_bcd  input  4*NUM_DIGITS  packed BCD from the counter; nibble i is digit i.
dp_mask  input  NUM_DIGITS  decimal point request per digit, active high.
seg_n  output  7  segments, active low; bit0=a … bit6=g.
dp_n  output  1  decimal point, active low.
an_n  output  NUM_DIGITS  anode select, active low, one-hot-low when active.
frame_start  output  1  one-cycle pulse when a snapshot is taken.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values (applied immediately on reset_n low, including mid-scan):
  - tick_cnt=0, digit_idx=0, snapshot=0
  - seg_n=7'h7F, dp_n=1, an_n=all ones, frame_start=0
- Prescaler:
  - tick_cnt has width $clog2(REFRESH_DIV) and counts 0..REFRESH_DIV-1 while en=1.
  - tick is asserted when tick_cnt=REFRESH_DIV-1; tick_cnt then wraps to 0.
- Digit index:
  - digit_idx advances on tick.
  - It wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - The snapshot registers capture digits_bcd and dp_mask when digit_idx wraps to 0.
  - They also capture on the first enabled cycle after reset or after an en rising edge.
  - frame_start=1 for exactly that cycle.
  - Input changes between snapshots have no effect on the display.
- en low:
  - tick_cnt and digit_idx hold; an_n is forced to all ones.
- en rising edge:
  - tick_cnt=0 and digit_idx=0, and a snapshot is taken.
- Outputs are registered: seg_n, dp_n and an_n reflect the digit_idx/tick_cnt state with 1-cycle latency.
- Guard:
  - an_n is all ones while the (registered) slot cycle count is < GUARD_CYCLES.
  - Otherwise an_n[digit_idx]=0 and all other anode bits are 1.
- Decode (active low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble values 10..15 display '-' = 3F.
- Leading-zero blanking: when BLANK_LEADING=1, digit i (i>0) shows seg_n=7F if its snapshot nibble and all nibbles above it are 0.
  - The anode is still driven.
  - dp_n still follows dp_mask.
  - Digit 0 is never blanked.
- dp_n = ~snapshot_dp[digit_idx] during the active (non-guard) window; otherwise 1.

Decomposition:
- Package rt_disp_pkg holds:
  - the SEG_* localparams for 0-9, SEG_DASH and SEG_BLANK
  - the BCD nibble typedef
- Sub-module bcd_to_7seg is a purely combinational nibble-to-seg_n decoder, instantiated once on the selected snapshot nibble.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles -> seg_n=7F, dp_n=1, an_n=4'hF, frame_start=0. Assert reset_n mid-slot -> same values immediately, without waiting for a clock edge.
2. Basic scan (REFRESH_DIV=4, GUARD_CYCLES=1): digits_bcd=16'h1234, en=1 -> frame_start pulses, then the anodes cycle E,D,B,7 with seg_n 19,30,24,79. Each anode is low for 3 of 4 cycles, and all anodes are F for 1 cycle per slot.
3. Snapshot: change digits_bcd to 16'h9999 during digit 2 -> display keeps showing 1234 until the next frame_start, then shows seg_n=10 on all digits.
4. Blanking: digits_bcd=16'h0070, dp_mask=4'b0100 -> digits 3 and 2 show seg_n=7F, digit 2 has dp_n=0, digit 1 shows 78, digit 0 shows 40. With BLANK_LEADING=0, digits 3 and 2 show 40.
5. Invalid BCD: digits_bcd=16'h00A5 -> digit 1 shows 3F, digit 0 shows 12, and digits 3 and 2 are blanked.
6. Enable: drop en mid-digit 2 for 10 cycles -> an_n=F and digit_idx/tick_cnt are frozen. Raise en -> frame_start pulses and the scan restarts at digit 0.
